// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM read-port arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam int unsigned ROM_SIZE_BIT_DEF = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Misaligned or beyond the last ROM word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned size_bit);
    return (addr[1:0] != 2'b00) || ((addr >> (size_bit + 2)) != 32'h0);
  endfunction

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive cycles port B lost; raises force_b_o at the limit.
module rom_arb_starve_ctr
  import rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic b_req_i,
  input  logic b_win_i,
  output logic force_b_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!b_req_i || b_win_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_b_o = b_req_i && (cnt_q == LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the instruction ROM; A has priority.
// Optional B starvation protection is built when ROM_ARB_FAIRNESS_EN is defined.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_SIZE_BIT = ROM_SIZE_BIT_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic        a_flush,
  output logic        a_gnt,
  output logic        a_valid,
  output logic [31:0] a_data,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  output logic        b_gnt,
  output logic        b_valid,
  output logic [31:0] b_data,
  output logic        b_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic        a_elig, b_win, a_win, force_b;
  logic [31:0] resp_word;

`ifdef ROM_ARB_FAIRNESS_EN
  rom_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i    (clk),
    .reset_i  (reset),
    .b_req_i  (b_req),
    .b_win_i  (b_win),
    .force_b_o(force_b)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_b = 1'b0;
`endif

  assign a_elig = a_req && !a_flush;
  assign b_win  = b_req && (!a_elig || force_b);
  assign a_win  = a_elig && !b_win;
  assign a_gnt  = a_win;
  assign b_gnt  = b_win;

  always_comb begin
    owner_d    = OWN_NONE;
    err_d      = 1'b0;
    rom_addr_d = rom_addr_q;
    if (a_win) begin
      owner_d    = OWN_A;
      err_d      = addr_err(a_addr, ROM_SIZE_BIT);
      rom_addr_d = word_align(a_addr);
    end else if (b_win) begin
      owner_d    = OWN_B;
      err_d      = addr_err(b_addr, ROM_SIZE_BIT);
      rom_addr_d = word_align(b_addr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      owner_q    <= owner_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign resp_word = err_q ? '0 : rom_data;

  // A late flush kills A's response in the same cycle it would appear.
  assign a_valid = (owner_q == OWN_A) && !a_flush;
  assign a_data  = a_valid ? resp_word : '0;
  assign a_err   = a_valid && err_q;

  assign b_valid = (owner_q == OWN_B);
  assign b_data  = b_valid ? resp_word : '0;
  assign b_err   = b_valid && err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter against a cycle-level behavioural model.
module tb_rom_arbiter;

  localparam int unsigned RSB = 8;
  localparam int unsigned SL  = 4;
`ifdef ROM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk, reset;
  logic        a_req, a_flush, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_gnt, a_valid, a_err, b_gnt, b_valid, b_err;
  logic [31:0] a_data, b_data, rom_addr, rom_data;

  int errors = 0;
  int checks = 0;

  // Model state: who got the last grant, its byte address, B's losing streak.
  int          m_owner;
  logic [31:0] m_addr;
  int          m_lost;
  logic [31:0] m_rom_addr;

  rom_arbiter #(.ROM_SIZE_BIT(RSB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_flush(a_flush),
    .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr),
    .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data), .b_err(b_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h3C3C_0F0F;
  endfunction

  assign rom_data = rom_word(rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || ({32'h0, a} >= (64'd4 << RSB));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return bad_addr(a) ? 32'h0 : rom_word(a);
  endfunction

  function automatic bit model_b_wins();
    bit a_el;
    a_el = a_req && !a_flush;
    return b_req && (!a_el || (FAIR && m_lost >= SL));
  endfunction

  function automatic bit model_a_wins();
    return a_req && !a_flush && !model_b_wins();
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) return 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
    if (kind == 1) return ($urandom | 32'h0000_0400) & ~32'h3;
    return 32'($urandom_range(0, 255) * 4);
  endfunction

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_lost = 0; m_rom_addr = '0;
  endtask

  task automatic tick();
    bit ga, gb;
    @(posedge clk);
    ga = model_a_wins();
    gb = model_b_wins();
    if (ga) begin m_owner = 1; m_addr = a_addr; end
    else if (gb) begin m_owner = 2; m_addr = b_addr; end
    else m_owner = 0;
    if (m_owner != 0) m_rom_addr = m_addr & ~32'h3;
    if (b_req && !gb) m_lost++; else m_lost = 0;
    #1;
  endtask

  task automatic drive(input logic ar, input logic [31:0] aa, input logic af,
                       input logic br, input logic [31:0] ba);
    a_req = ar; a_addr = aa; a_flush = af; b_req = br; b_addr = ba;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({a_valid, b_valid, a_err, b_err, a_gnt, b_gnt} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {a_valid, b_valid, a_err, b_err, a_gnt, b_gnt});
    end
    checks++;
    if (a_data !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_data); end
    checks++;
    if (b_data !== 32'h0) begin errors++; $display("FAIL reset_b_data: got %h expected 0", b_data); end
    checks++;
    if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    drive(1, 32'h40, 0, 1, 32'h80);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL reset_gnt_comb: got %b expected 10", {a_gnt, b_gnt}); end
    @(posedge clk); #2;
    checks++;
    if (a_valid !== 1'b0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL reset_hold: got valid=%b addr=%h expected 0/0", a_valid, rom_addr);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_a_only();
    drive(1, 32'h10, 0, 0, 0);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL a_only_gnt: got %b expected 10", {a_gnt, b_gnt}); end
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (rom_addr !== 32'h10) begin errors++; $display("FAIL a_only_rom_addr: got %h expected 00000010", rom_addr); end
    checks++;
    if (a_valid !== 1'b1 || a_err !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL a_only_valid: got a_valid=%b a_err=%b b_valid=%b expected 1 0 0", a_valid, a_err, b_valid);
    end
    checks++;
    if (a_data !== rom_word(32'h10)) begin errors++; $display("FAIL a_only_data: got %h expected %h", a_data, rom_word(32'h10)); end
    tick();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL a_only_idle: got a_valid=%b expected 0", a_valid); end
  endtask

  task automatic test_starvation();
    int n_b, first_b, exp_n, exp_first;
    bit exp_b;
    n_b = 0; first_b = -1;
    for (int i = 0; i < 100; i++) begin
      drive(1, 32'($urandom_range(0, 255) * 4), 0, 1, 32'($urandom_range(0, 255) * 4));
      exp_b = model_b_wins();
      checks++;
      if (b_gnt !== exp_b || a_gnt !== !exp_b) begin
        errors++; $display("FAIL starve_gnt[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_gnt, b_gnt, !exp_b, exp_b);
      end
      if (b_gnt === 1'b1) begin
        n_b++;
        if (first_b < 0) first_b = i;
      end
      tick();
    end
    exp_n     = FAIR ? 100 / (SL + 1) : 0;
    exp_first = FAIR ? SL : -1;
    checks++;
    if (n_b !== exp_n) begin errors++; $display("FAIL starve_count: got %0d expected %0d", n_b, exp_n); end
    checks++;
    if (first_b !== exp_first) begin errors++; $display("FAIL starve_first: got %0d expected %0d", first_b, exp_first); end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_bad_addr();
    drive(0, 0, 0, 1, 32'h402);
    checks++;
    if (b_gnt !== 1'b1) begin errors++; $display("FAIL bad_b_gnt: got %b expected 1", b_gnt); end
    tick();
    drive(1, 32'h400, 0, 0, 0);
    checks++;
    if ({b_valid, b_err} !== 2'b11 || b_data !== 32'h0) begin
      errors++; $display("FAIL bad_b_resp: got valid=%b err=%b data=%h expected 1 1 0", b_valid, b_err, b_data);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({a_valid, a_err} !== 2'b11 || a_data !== 32'h0) begin
      errors++; $display("FAIL bad_a_resp: got valid=%b err=%b data=%h expected 1 1 0", a_valid, a_err, a_data);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h24, 0, 0, 0);
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL flush_pre_gnt: got %b expected 1", a_gnt); end
    tick();
    drive(1, 32'h28, 1, 1, 32'h30);
    checks++;
    if ({a_valid, a_gnt, b_gnt} !== 3'b001) begin
      errors++; $display("FAIL flush_cycle: got a_valid=%b a_gnt=%b b_gnt=%b expected 0 0 1", a_valid, a_gnt, b_gnt);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (b_valid !== 1'b1 || b_data !== rom_word(32'h30) || a_valid !== 1'b0) begin
      errors++; $display("FAIL flush_b_resp: got b_valid=%b b_data=%h a_valid=%b expected 1 %h 0", b_valid, b_data, a_valid, rom_word(32'h30));
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    drive(1, 32'h44, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got a_valid=%b expected 1", a_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL inflight_async: got a_valid=%b rom_addr=%h expected 0 0", a_valid, rom_addr);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    drive(1, 32'h48, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_data !== rom_word(32'h48)) begin
      errors++; $display("FAIL inflight_after: got a_valid=%b a_data=%h expected 1 %h", a_valid, a_data, rom_word(32'h48));
    end
    tick();
  endtask

  task automatic test_random();
    bit ev_a, ev_b, ga, gb;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 99) < 15,
            $urandom_range(0, 1) == 1, rand_addr());
      ga = model_a_wins();
      gb = model_b_wins();
      ev_a = (m_owner == 1) && !a_flush;
      ev_b = (m_owner == 2);
      checks++;
      if ({a_gnt, b_gnt} !== {ga, gb}) begin
        errors++; $display("FAIL rand_gnt[%0d]: got %b%b expected %b%b", i, a_gnt, b_gnt, ga, gb);
      end
      checks++;
      if ({a_valid, b_valid} !== {ev_a, ev_b}) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b%b expected %b%b", i, a_valid, b_valid, ev_a, ev_b);
      end
      checks++;
      if (rom_addr !== m_rom_addr) begin
        errors++; $display("FAIL rand_rom_addr[%0d]: got %h expected %h", i, rom_addr, m_rom_addr);
      end
      if (!(m_owner == 1 && a_flush)) begin
        checks++;
        if (a_data !== (ev_a ? exp_word(m_addr) : 32'h0) || a_err !== (ev_a && bad_addr(m_addr))) begin
          errors++; $display("FAIL rand_a_resp[%0d]: got %h/%b expected %h/%b", i, a_data, a_err,
                             ev_a ? exp_word(m_addr) : 32'h0, ev_a && bad_addr(m_addr));
        end
      end
      checks++;
      if (b_data !== (ev_b ? exp_word(m_addr) : 32'h0) || b_err !== (ev_b && bad_addr(m_addr))) begin
        errors++; $display("FAIL rand_b_resp[%0d]: got %h/%b expected %h/%b", i, b_data, b_err,
                           ev_b ? exp_word(m_addr) : 32'h0, ev_b && bad_addr(m_addr));
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_starvation();
    test_bad_addr();
    test_flush();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
